// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 matrix keypad scanner.
//   state_t        scanner FSM states
//   KeyMap         hex code per [row][col] position
//   Col0..Col3     one-hot column drive values
//   onehot_to_idx  index of the lowest set bit of a 4-bit vector
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } state_t;

  // Indexed as KeyMap[row][col].
  localparam logic [3:0] KeyMap [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  localparam logic [3:0] Col0 = 4'b0001;
  localparam logic [3:0] Col1 = 4'b0010;
  localparam logic [3:0] Col2 = 4'b0100;
  localparam logic [3:0] Col3 = 4'b1000;

  // Lowest set bit wins, so the same helper also picks the row when several are active.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] vec);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (vec[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: parameterized-width two-flop synchronizer.
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset, flops clear to 0
//   d_i     asynchronous input bits
//   q_o     synchronized output, two clk_i cycles of latency
module keypad_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync1_d, sync1_q;
  logic [Width-1:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = d_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scan FSM for a 4x4 matrix keypad with press/release debounce.
//   clk        system clock
//   reset      asynchronous active-low reset (release expected synchronous to clk)
//   row_keys   raw active-high rows, asynchronous to clk
//   col_keys   one-hot active-high column drive
//   key_code   hex code of the last accepted key, held until the next accept
//   key_valid  one-cycle strobe marking a newly valid key_code
//   key_held   high from accept until release debounce completes
// Optional feature: define KEYPAD_REPEAT_EN to re-strobe key_valid every REPEAT_CYC cycles
// while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 4800,
  parameter int unsigned DEBOUNCE_CYC = 48000,
  parameter int unsigned REPEAT_CYC   = 480000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_keys,
  output logic [3:0] col_keys,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CntMax = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t ScanLast = cnt_t'(SCAN_DIV - 1);
  localparam cnt_t DebLast  = cnt_t'(DEBOUNCE_CYC - 1);
  // Rows need two cycles through the synchronizer after a column change before they are valid.
  localparam cnt_t SettleCnt = cnt_t'(2);

  state_t     state_d, state_q;
  cnt_t       cnt_d, cnt_q;
  logic [3:0] col_d, col_q;
  logic [1:0] row_idx_d, row_idx_q;
  logic [3:0] key_code_d, key_code_q;
  logic       key_valid_d, key_valid_q;
  logic       key_held_d, key_held_q;

  logic [3:0] row_s;
  logic       row_hit;
  logic       col_ok;
  logic [3:0] col_next;

  keypad_sync #(
    .Width(4)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (row_keys),
    .q_o   (row_s)
  );

  assign row_hit  = row_s[row_idx_q];
  assign col_ok   = col_q inside {Col0, Col1, Col2, Col3};
  assign col_next = col_ok ? {col_q[2:0], col_q[3]} : Col0;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_CYC);
  typedef logic [RepW-1:0] rep_t;
  localparam rep_t RepLast = rep_t'(REPEAT_CYC - 1);

  rep_t rep_d, rep_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  logic unused_repeat_cyc;
  assign unused_repeat_cyc = ^REPEAT_CYC;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    // Cleared everywhere except while counting in HELD, which covers HELD entry and RELEASE.
    rep_d = '0;
`endif

    unique case (state_q)
      StScan: begin
        if (row_s != 4'b0000 && cnt_q >= SettleCnt) begin
          row_idx_d = onehot_to_idx(row_s);
          cnt_d     = '0;
          state_d   = StDebounce;
        end else if (cnt_q >= ScanLast) begin
          cnt_d = '0;
          col_d = col_next;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      StDebounce: begin
        if (!row_hit) begin
          cnt_d   = '0;
          col_d   = col_next;
          state_d = StScan;
        end else if (cnt_q >= DebLast) begin
          key_code_d  = KeyMap[row_idx_q][onehot_to_idx(col_q)];
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          cnt_d       = '0;
          state_d     = StHeld;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      StHeld: begin
        if (!row_hit) begin
          cnt_d   = '0;
          state_d = StRelease;
        end else begin
`ifdef KEYPAD_REPEAT_EN
          if (rep_q >= RepLast) begin
            key_valid_d = 1'b1;
          end else begin
            rep_d = rep_q + rep_t'(1);
          end
`endif
        end
      end

      StRelease: begin
        if (row_hit) begin
          // Glitch during release: back to HELD without a new strobe.
          cnt_d   = '0;
          state_d = StHeld;
        end else if (cnt_q >= DebLast) begin
          key_held_d = 1'b0;
          cnt_d      = '0;
          col_d      = col_next;
          state_d    = StScan;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = StScan;
      end
    endcase

    // A corrupted column drive recovers to column 0 regardless of state.
    if (!col_ok) col_d = Col0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StScan;
      cnt_q       <= '0;
      col_q       <= Col0;
      row_idx_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_idx_q   <= row_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col_keys  = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner
// (SCAN_DIV=8, DEBOUNCE_CYC=16, REPEAT_CYC=64). Honours KEYPAD_REPEAT_EN.
module tb_keypad_scanner;

  localparam int unsigned ScanDiv = 8;
  localparam int unsigned DebCyc  = 16;
  localparam int unsigned RepCyc  = 64;
  // Rows set at a column's first sample: sync (2) + settle detect (1) + debounce (16).
  localparam int AcceptLat = 19;
`ifdef KEYPAD_REPEAT_EN
  localparam int ExpHoldStrobes = 4;
  localparam int ExpLastStrobe  = AcceptLat + 192;
`else
  localparam int ExpHoldStrobes = 1;
  localparam int ExpLastStrobe  = AcceptLat;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_keys = 4'b0000;
  logic [3:0] col_keys;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int         n_chk = 0;
  int         n_bad = 0;
  int         n_strobe = 0;
  int         n_b2b = 0;
  int         cyc = 0;
  int         last_strobe_cyc = 0;
  int         strobe_gap = 0;
  logic       kv_prev = 1'b0;
  logic [3:0] last_code = 4'h0;

  keypad_scanner #(
    .SCAN_DIV    (ScanDiv),
    .DEBOUNCE_CYC(DebCyc),
    .REPEAT_CYC  (RepCyc)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row_keys (row_keys),
    .col_keys (col_keys),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and log any strobe seen there.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (key_valid === 1'b1) begin
      if (kv_prev) n_b2b++;
      n_strobe++;
      strobe_gap      = cyc - last_strobe_cyc;
      last_strobe_cyc = cyc;
      last_code       = key_code;
    end
    kv_prev = key_valid;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Wait for the first sample of column c (counter at 0).
  task automatic wait_col(input logic [3:0] c);
    int n;
    n = 0;
    while (col_keys === c && n < 64) begin
      tick();
      n++;
    end
    while (col_keys !== c && n < 64) begin
      tick();
      n++;
    end
    chk("wait_col", col_keys, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int c0;

    // Reset values
    ticks(3);
    chk("rst_col", col_keys, 4'b0001);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    reset = 1'b1;

    // 1: idle scan, 8 cycles per column
    for (int i = 0; i < 40; i++) begin
      chk("scan_col", col_keys, 32'd1 << ((i / 8) % 4));
      tick();
    end
    chk("scan_no_strobe", n_strobe, 0);

    // 2: key 6 (row1, col2)
    wait_col(4'b0100);
    s0       = n_strobe;
    c0       = cyc;
    row_keys = 4'b0010;
    ticks(40);
    chk("k6_strobes", n_strobe - s0, 1);
    chk("k6_latency", last_strobe_cyc - c0, AcceptLat);
    chk("k6_code", key_code, 4'h6);
    chk("k6_held", key_held, 1'b1);
    chk("k6_col_frozen", col_keys, 4'b0100);
    row_keys = 4'b0000;
    ticks(20);
    chk("k6_released", key_held, 1'b0);
    chk("k6_next_col", col_keys, 4'b1000);

    // 3: bounce at col 0100, never stable long enough
    wait_col(4'b0100);
    s0 = n_strobe;
    for (int i = 0; i < 30; i++) begin
      row_keys = (((i / 5) % 2) == 0) ? 4'b0010 : 4'b0000;
      if (i == 8) chk("bounce_resume_col", col_keys, 4'b1000);
      tick();
    end
    row_keys = 4'b0000;
    ticks(5);
    chk("bounce_strobes", n_strobe - s0, 0);
    chk("bounce_held", key_held, 1'b0);
    chk("bounce_code_kept", key_code, 4'h6);

    // 4: key 5 with a glitch high during release
    wait_col(4'b0010);
    s0       = n_strobe;
    row_keys = 4'b0010;
    ticks(30);
    chk("k5_code", key_code, 4'h5);
    chk("k5_held", key_held, 1'b1);
    row_keys = 4'b0000;
    ticks(6);
    row_keys = 4'b0010;
    ticks(4);
    row_keys = 4'b0000;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 18) chk("k5_held_before_end", key_held, 1'b1);
      if (k == 19) chk("k5_held_cleared", key_held, 1'b0);
    end
    chk("k5_strobes", n_strobe - s0, 1);

    // 5: two rows at col 0001, then a second key, then reset in HELD
    wait_col(4'b0001);
    s0       = n_strobe;
    row_keys = 4'b0101;
    ticks(25);
    chk("k1_code", last_code, 4'h1);
    chk("k1_strobes", n_strobe - s0, 1);
    row_keys = 4'b0111;
    ticks(20);
    chk("k1_second_key_strobes", n_strobe - s0, 1);
    chk("k1_held", key_held, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_col", col_keys, 4'b0001);
    chk("mid_rst_code", key_code, 4'h0);
    chk("mid_rst_valid", key_valid, 1'b0);
    chk("mid_rst_held", key_held, 1'b0);
    row_keys = 4'b0000;
    ticks(2);
    reset = 1'b1;
    chk("post_rst_col", col_keys, 4'b0001);

    // 6: key A held 200 cycles past accept
    wait_col(4'b1000);
    s0       = n_strobe;
    c0       = cyc;
    row_keys = 4'b0001;
    ticks(25);
    chk("kA_first_latency", last_strobe_cyc - c0, AcceptLat);
    ticks(194);
    chk("kA_strobes", n_strobe - s0, ExpHoldStrobes);
    chk("kA_last_strobe", last_strobe_cyc - c0, ExpLastStrobe);
`ifdef KEYPAD_REPEAT_EN
    chk("kA_gap", strobe_gap, RepCyc);
`endif
    chk("kA_code", last_code, 4'hA);
    row_keys = 4'b0000;
    ticks(25);
    chk("kA_released", key_held, 1'b0);

    chk("no_back_to_back", n_b2b, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
